pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/pipeline_hazard_ctrl_hazard_history.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 90 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types, field positions and match helper for the hazard controller
package pipeline_pkg;

   localparam int REG_W  = 5;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic             valid;
      logic             wr;
      logic             load;
      logic [REG_W-1:0] dest;
   } hist_entry_t;

   function automatic logic src_match(input hist_entry_t e, input logic [REG_W-1:0] src);
      return e.valid & e.wr & (e.dest == src);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - fetch-side decode inputs and hazard/forward controls
interface pipeline_hazard_ctrl_if;

   logic [31:0] instr;
   logic        reg_wr;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        uses_rt;
   logic        branch_taken;

   logic        ex_forward_a;
   logic        ex_forward_b;
   logic        mem_forward_a;
   logic        mem_forward_b;
   logic        pc_write;
   logic        bubble;
   logic [1:0]  busy_state;

   modport master (
      output instr, reg_wr, reg_dst, mem_to_reg, uses_rt, branch_taken,
      input  ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b,
      input  pc_write, bubble, busy_state
   );

   modport slave (
      input  instr, reg_wr, reg_dst, mem_to_reg, uses_rt, branch_taken,
      output ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b,
      output pc_write, bubble, busy_state
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_history.sv
// rtl/pipeline_hazard_ctrl_hazard_history.sv - two-deep history of in-flight destination registers
module hazard_history
   import pipeline_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  logic             push_wr,
   input  logic             push_load,
   input  logic [REG_W-1:0] push_dest,
   output hist_entry_t      hist0,
   output hist_entry_t      hist1
);

   hist_entry_t incoming;

   // Writes to $0 are stored as non-writing so they can never forward.
   always_comb begin
      incoming.valid = push_valid;
      incoming.wr    = push_wr & (push_dest != REG_ZERO);
      incoming.load  = push_load;
      incoming.dest  = push_dest;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist0 <= '0;
         hist1 <= '0;
      end else begin
         hist1 <= hist0;
         hist0 <= incoming;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - forwarding selects, load-use stall and branch flush control
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_ADDR_W   = REG_W
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam logic [1:0] RUN        = ST_RUN;
   localparam logic [1:0] STALL      = ST_STALL;
   localparam logic [1:0] FLUSH      = ST_FLUSH;
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [REG_ADDR_W-1:0] rs, rt, rd, dest;
   hist_entry_t           h0, h1;
   logic [1:0]            state_q, state_cur, state_nxt;
   logic [2:0]            cnt_q, cnt_nxt;
   logic                  ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic                  hazard, bubble;
   logic                  unused_bits;

   assign rs   = hz.instr[RS_MSB:RS_LSB];
   assign rt   = hz.instr[RT_MSB:RT_LSB];
   assign rd   = hz.instr[RD_MSB:RD_LSB];
   assign dest = hz.reg_dst ? rd : rt;

   assign unused_bits = ^{hz.instr[31:26], hz.instr[10:0], h1.load};

   hazard_history u_history (
      .clk        (clk),
      .rst        (rst),
      .push_valid (~bubble),
      .push_wr    (hz.reg_wr),
      .push_load  (hz.mem_to_reg),
      .push_dest  (dest),
      .hist0      (h0),
      .hist1      (h1)
   );

   assign ex_hit_a  = src_match(h0, rs);
   assign ex_hit_b  = hz.uses_rt & src_match(h0, rt);
   assign mem_hit_a = src_match(h1, rs);
   assign mem_hit_b = hz.uses_rt & src_match(h1, rt);

   // Only a load one stage ahead stalls; one two stages ahead is served by the MEM forward.
   assign hazard = h0.load & (ex_hit_a | ex_hit_b);

   // The stall cycle is the fetch cycle itself, so the penalty stays at exactly one.
   always_comb begin
      state_cur = state_q;
      if (state_q == RUN && hazard && !hz.branch_taken)
         state_cur = STALL;
   end

   always_comb begin
      state_nxt = RUN;
      cnt_nxt   = '0;
      if (hz.branch_taken) begin
         state_nxt = FLUSH;
         cnt_nxt   = FLUSH_LOAD;
      end else if (state_cur == FLUSH && cnt_q != 3'd0) begin
         state_nxt = FLUSH;
         cnt_nxt   = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign bubble           = (state_cur != RUN);
   assign hz.bubble        = bubble;
   assign hz.pc_write      = (state_cur != STALL);
   assign hz.busy_state    = state_cur;
   assign hz.ex_forward_a  = ex_hit_a  & ~bubble;
   assign hz.ex_forward_b  = ex_hit_b  & ~bubble;
   assign hz.mem_forward_a = mem_hit_a & ~bubble;
   assign hz.mem_forward_b = mem_hit_b & ~bubble;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vectors plus per-cycle model comparison for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int FLUSH_CYCLES = 2;

   // {ex_fwd_a, ex_fwd_b, mem_fwd_a, mem_fwd_b, pc_write, bubble, busy_state[1:0]}
   localparam logic [7:0] E_RUN   = 8'b0000_1_0_00;
   localparam logic [7:0] E_STALL = 8'b0000_0_1_01;
   localparam logic [7:0] E_FLUSH = 8'b0000_1_1_10;
   localparam logic [7:0] E_EX_AB = 8'b1100_1_0_00;
   localparam logic [7:0] E_MEM_A = 8'b0010_1_0_00;

   logic clk = 1'b0;
   logic rst;

   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit valid;
      bit wr;
      bit load;
      int dest;
   } m_ent_t;

   m_ent_t mh [2] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
   int     flush_left = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hit(input m_ent_t e, input int src);
      return e.valid && e.wr && (e.dest == src);
   endfunction

   function automatic int f_rs();
      return int'(hz.instr[25:21]);
   endfunction

   function automatic int f_rt();
      return int'(hz.instr[20:16]);
   endfunction

   function automatic int f_dest();
      return hz.reg_dst ? int'(hz.instr[15:11]) : int'(hz.instr[20:16]);
   endfunction

   function automatic bit exp_stall();
      return (flush_left == 0) && !hz.branch_taken && mh[0].load &&
             (hit(mh[0], f_rs()) || (hz.uses_rt && hit(mh[0], f_rt())));
   endfunction

   function automatic bit exp_bubble();
      return (flush_left > 0) || exp_stall();
   endfunction

   function automatic logic [7:0] model_expect();
      bit         st, bub;
      logic [1:0] busy;
      st   = exp_stall();
      bub  = exp_bubble();
      busy = (flush_left > 0) ? 2'd2 : (st ? 2'd1 : 2'd0);
      return {!bub && hit(mh[0], f_rs()),
              !bub && hz.uses_rt && hit(mh[0], f_rt()),
              !bub && hit(mh[1], f_rs()),
              !bub && hz.uses_rt && hit(mh[1], f_rt()),
              !st, bub, busy};
   endfunction

   function automatic m_ent_t new_entry();
      m_ent_t e;
      e.valid = !exp_bubble();
      e.wr    = hz.reg_wr && (f_dest() != 0);
      e.load  = hz.mem_to_reg;
      e.dest  = f_dest();
      return e;
   endfunction

   function automatic logic [7:0] dut_vec();
      return {hz.ex_forward_a, hz.ex_forward_b, hz.mem_forward_a, hz.mem_forward_b,
              hz.pc_write, hz.bubble, hz.busy_state};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mh[0]      <= '{0, 0, 0, 0};
         mh[1]      <= '{0, 0, 0, 0};
         flush_left <= 0;
      end else begin
         mh[1]      <= mh[0];
         mh[0]      <= new_entry();
         flush_left <= hz.branch_taken ? FLUSH_CYCLES : ((flush_left > 0) ? flush_left - 1 : 0);
      end
   end

   always @(negedge clk) begin
      check("model_cycle", int'(dut_vec()), int'(model_expect()));
   end

   function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic wr, input logic dst,
                        input logic ld, input logic urt, input logic br);
      hz.instr        = ins;
      hz.reg_wr       = wr;
      hz.reg_dst      = dst;
      hz.mem_to_reg   = ld;
      hz.uses_rt      = urt;
      hz.branch_taken = br;
   endtask

   task automatic step(input string name, input logic [31:0] ins, input logic wr, input logic dst,
                       input logic ld, input logic urt, input logic br, input logic [7:0] exp);
      drive(ins, wr, dst, ld, urt, br);
      @(negedge clk);
      check(name, int'(dut_vec()), int'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      drive(r_ins(1, 2, 3), 1, 1, 0, 1, 0);
      repeat (2) begin
         @(negedge clk);
         check("reset_outputs", int'(dut_vec()), int'(E_RUN));
      end
      @(posedge clk);
      #1;
      rst = 1'b1;

      step("add3_empty_history",  r_ins(1, 2, 3),     1, 1, 0, 1, 0, E_RUN);
      step("add4",                r_ins(1, 2, 4),     1, 1, 0, 1, 0, E_RUN);
      step("sub5_ex_fwd_ab",      r_ins(4, 4, 5),     1, 1, 0, 1, 0, E_EX_AB);
      step("or6_mem_fwd_a",       r_ins(4, 0, 6),     1, 1, 0, 1, 0, E_MEM_A);
      step("lw7",                 i_ins(35, 1, 7, 0), 1, 0, 1, 0, 0, E_RUN);
      step("add8_load_use_stall", r_ins(7, 2, 8),     1, 1, 0, 1, 0, E_STALL);
      step("add8_represent",      r_ins(7, 2, 8),     1, 1, 0, 1, 0, E_MEM_A);
      step("addi_to_zero",        i_ins(8, 1, 0, 5),  1, 0, 0, 0, 0, E_RUN);
      step("add9_reads_zero",     r_ins(0, 0, 9),     1, 1, 0, 1, 0, E_RUN);
      step("beq_taken",           i_ins(4, 9, 9, 0),  0, 0, 0, 1, 1, E_EX_AB);
      step("flush_1",             32'd0,              0, 0, 0, 0, 0, E_FLUSH);
      step("flush_2",             32'd0,              0, 0, 0, 0, 0, E_FLUSH);
      step("run_after_flush",     r_ins(1, 2, 10),    1, 1, 0, 1, 0, E_RUN);
      step("branch_again",        32'd0,              0, 0, 0, 0, 1, E_RUN);
      step("flush_reload",        32'd0,              0, 0, 0, 0, 1, E_FLUSH);
      step("flush_reload_2",      32'd0,              0, 0, 0, 0, 0, E_FLUSH);
      step("flush_reload_3",      32'd0,              0, 0, 0, 0, 0, E_FLUSH);
      step("run_after_reload",    32'd0,              0, 0, 0, 0, 0, E_RUN);
      step("lw11",                i_ins(35, 1, 11, 0),1, 0, 1, 0, 0, E_RUN);
      step("hazard_and_branch",   r_ins(11, 11, 12),  1, 1, 0, 1, 1, E_EX_AB);
      step("flush_no_stall",      32'd0,              0, 0, 0, 0, 0, E_FLUSH);

      rst = 1'b0;
      #1;
      check("reset_mid_flush_pc_write", int'(hz.pc_write),   1);
      check("reset_mid_flush_bubble",   int'(hz.bubble),     0);
      check("reset_mid_flush_state",    int'(hz.busy_state), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step("post_reset_empty_history", r_ins(11, 12, 13), 1, 1, 0, 1, 0, E_RUN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
